// File: rtl/bit_serial_adder.sv
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first,
// through a single full-adder cell with a registered carry.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one result bit per edge, WIDTH edges in total
// DONE  | one-cycle done pulse; sum/cout hold the fresh result
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cy_q, cy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] acc_shift;

    // Shared one-bit full-adder cell fed from the operand LSBs and the carry flop.
    always_comb begin
        fa_s = opa_q[0] ^ opb_q[0] ^ cy_q;
        fa_c = (opa_q[0] & opb_q[0]) | (opa_q[0] & cy_q) | (opb_q[0] & cy_q);
        // New bit enters at the MSB; written with shifts so WIDTH=1 needs no special case.
        acc_shift = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    end

    // Next-state and datapath update; every register holds unless its state acts on it.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    cy_d    = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_shift;
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                cy_d  = fa_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Output registers only change here, so partial results never show.
                    sum_d   = acc_shift;
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Status decoded from registered state only; no path from start.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder at WIDTH=8 and WIDTH=1.
module tb_bit_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int compared;
    int mismatched;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One WIDTH=8 operation; operands are scrambled right after acceptance.
    // k counts negedges after the accepting edge E0.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        output int lat, output int busy_cnt, output logic done_after,
                        output logic [7:0] rs, output logic rc);
        int k;
        @(negedge clk);
        a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~ta; b8 = ~tb_v; cin8 = ~tc;
        k = 0;
        busy_cnt = 0;
        while (!done8 && k < 40) begin
            if (busy8) busy_cnt++;
            @(negedge clk);
            k++;
        end
        lat = k;
        rs = sum8;
        rc = cout8;
        @(negedge clk);
        done_after = done8;
    endtask

    task automatic run1(input logic ta, input logic tb_v, input logic tc,
                        output int lat, output logic rs, output logic rc);
        int k;
        @(negedge clk);
        a1 = ta; b1 = tb_v; cin1 = tc; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; a1 = ~ta; b1 = ~tb_v; cin1 = ~tc;
        k = 0;
        while (!done1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        lat = k;
        rs = sum1[0];
        rc = cout1;
    endtask

    initial begin
        vec_t       vecs[11];
        int         lat, bcnt, nd, busy_after, changes;
        int         t_first, t_second;
        logic       dafter, rc;
        logic [7:0] rs;
        logic       rs1;
        logic [8:0] exp9;
        logic [1:0] exp2;
        logic [7:0] ra, rb;
        logic       rcin;

        compared = 0;
        mismatched = 0;

        vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0};
        vecs[7]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[8]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[9]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[10] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        check("reset_sum",  32'(sum8),  32'd0);
        check("reset_cout", 32'(cout8), 32'd0);
        rst = 1'b0;

        // Table-driven vectors, each also checking latency and pulse shape.
        for (int i = 0; i < 11; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt, dafter, rs, rc);
            check("vec_sum",     32'(rs),     32'(vecs[i].exp_sum));
            check("vec_cout",    32'(rc),     32'(vecs[i].exp_cout));
            check("vec_latency", 32'(lat),    32'd8);
            check("vec_busy",    32'(bcnt),   32'd8);
            check("vec_pulse",   32'(dafter), 32'd0);
        end

        // Start pulsed during RUN and DONE with other operands must be ignored.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        nd = 0;
        busy_after = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (done8) begin
                nd++;
                check("ign_sum",  32'(sum8),  32'h46);
                check("ign_cout", 32'(cout8), 32'd0);
                start8 = 1'b1;
            end else begin
                start8 = (k == 3) ? 1'b1 : 1'b0;
            end
            if (k >= 9 && busy8) busy_after++;
        end
        start8 = 1'b0;
        check("ign_done_count", 32'(nd),         32'd1);
        check("ign_no_restart", 32'(busy_after), 32'd0);

        // Reset in cycle 4 of RUN abandons the operation.
        @(negedge clk);
        a8 = 8'hAB; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy8), 32'd0);
        check("rst_mid_done", 32'(done8), 32'd0);
        check("rst_mid_sum",  32'(sum8),  32'd0);
        check("rst_mid_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done8 || busy8) nd++;
        end
        check("rst_no_done", 32'(nd), 32'd0);
        run8(8'h01, 8'h01, 1'b0, lat, bcnt, dafter, rs, rc);
        check("rst_after_sum",  32'(rs), 32'h02);
        check("rst_after_cout", 32'(rc), 32'd0);

        // Back-to-back with start held high.
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b1;
        t_first = -1;
        t_second = -1;
        changes = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done8) begin
                if (t_first < 0) begin
                    t_first = k;
                    check("b2b_sum1",  32'(sum8),  32'h00);
                    check("b2b_cout1", 32'(cout8), 32'd1);
                end else if (t_second < 0) begin
                    t_second = k;
                    start8 = 1'b0;
                    check("b2b_sum2",  32'(sum8),  32'h11);
                    check("b2b_cout2", 32'(cout8), 32'd0);
                end
            end else if (t_first >= 0 && t_second < 0) begin
                if (sum8 !== 8'h00 || cout8 !== 1'b1) changes++;
            end
        end
        start8 = 1'b0;
        check("b2b_first_at", 32'(t_first), 32'd8);
        check("b2b_spacing",  32'(t_second - t_first), 32'd10);
        check("b2b_stable",   32'(changes), 32'd0);

        // WIDTH=1 directed corners.
        run1(1'b1, 1'b1, 1'b1, lat, rs1, rc);
        check("w1_sum_111",  32'(rs1), 32'd1);
        check("w1_cout_111", 32'(rc),  32'd1);
        check("w1_latency",  32'(lat), 32'd1);
        run1(1'b1, 1'b0, 1'b0, lat, rs1, rc);
        check("w1_sum_100",  32'(rs1), 32'd1);
        check("w1_cout_100", 32'(rc),  32'd0);

        // Random operands against the arithmetic definition.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rcin = 1'($urandom_range(0, 1));
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rcin};
            run8(ra, rb, rcin, lat, bcnt, dafter, rs, rc);
            check("rand8", 32'({rc, rs}), 32'(exp9));
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 1));
            rb = 8'($urandom_range(0, 1));
            rcin = 1'($urandom_range(0, 1));
            exp2 = {1'b0, ra[0]} + {1'b0, rb[0]} + {1'b0, rcin};
            run1(ra[0], rb[0], rcin, lat, rs1, rc);
            check("rand1", 32'({rc, rs1}), 32'(exp2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
